// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
// The receive block is expected to import this package as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO for transmit bytes.
// Full/empty are registered and derived from the next occupancy value,
// so they change on the same edge as the push/pop that moves them.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = UART_DATA_BITS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic [AW:0]       w_count_nxt;

    // Offers while full are dropped; pops while empty are ignored.
    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && !r_empty;

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate access.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO, baud counter, framing FSM, shift register.
// Default frame is 8N1. Defining UART_TX_PARITY_EN inserts an even-parity
// bit between the data bits and the stop bit (8E1).
// txd and tx_busy are registered one cycle behind the FSM state, so the
// byte popped at edge N shows its start bit from edge N+1.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             tx_enable,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             tx_full,
    output logic             tx_empty,
    output logic             tx_busy,
    output logic             txd
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e          r_state;
    uart_tx_state_e          w_state_nxt;
    logic [DIV_W-1:0]        r_cnt;
    logic [DIV_W-1:0]        w_cnt_nxt;
    logic [2:0]              r_bit;
    logic [2:0]              w_bit_nxt;
    logic [7:0]              r_shift;
    logic [7:0]              w_shift_nxt;
    logic [DIV_W-1:0]        r_div;
    logic [DIV_W-1:0]        w_div_nxt;
    logic                    r_txd;
    logic                    w_txd_nxt;
    logic                    r_busy;
`ifdef UART_TX_PARITY_EN
    logic                    r_par;
    logic                    w_par_nxt;
`endif

    logic                    w_pop;
    logic                    w_tick;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [7:0]              w_fifo_rdata;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (UART_DATA_BITS)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_push  (wr_valid),
        .i_wdata (wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_tick = (r_cnt == r_div);

    // Next-state, counters, shift register and line level for the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_div_nxt   = r_div;
        w_txd_nxt   = UART_IDLE_LEVEL;
        w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            IDLE: begin
                if (tx_enable && !w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_rdata;
                    w_div_nxt   = baud_div;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^w_fifo_rdata;
`endif
                end
            end
            START: begin
                w_txd_nxt = 1'b0;
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                w_txd_nxt = r_shift[0];
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                w_txd_nxt = r_par;
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STOP;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            STOP: begin
                w_txd_nxt = UART_IDLE_LEVEL;
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control state; reset abandons any frame and returns the line to idle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_txd   <= UART_IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= (r_state != IDLE);
        end
    end

    // Frame data and latched divisor; only read while a frame is active.
    always_ff @(posedge PCLK) begin
        r_shift <= w_shift_nxt;
        r_div   <= w_div_nxt;
`ifdef UART_TX_PARITY_EN
        r_par   <= w_par_nxt;
`endif
    end

    assign txd      = r_txd;
    assign tx_busy  = r_busy;
    assign tx_full  = w_fifo_full;
    assign tx_empty = w_fifo_empty;
    assign wr_ready = !w_fifo_full;

endmodule
